pipeline_if_stage: RTL and testbench
====================================

Name: pipeline_if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Owns the PC and drives the instruction-memory address.
- Waits on MIO_ready and applies redirects from ID (branch, j, jal, jr) and from CP0 (exception vector, eret to EPC).
- Presents id_instruction / id_pc / id_pcPlus4 to the ID-stage control decoder and register file, honouring its stall and redirect outputs.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
EXC_VECTOR, 32'h0000_0008, PC loaded when exception is asserted.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  reset, synchronous, active-high.
imem_addr  out  32  instruction-memory word address (byte address, [1:0]=0).
imem_req  out  1  fetch request; equals !rst.
imem_data  in  32  instruction word; valid when MIO_ready=1.
MIO_ready  in  1  memory handshake; 1 = imem_data valid for imem_addr this cycle.
shouldStall  in  1  data-hazard stall from ID control; hold PC and IF/ID.
shouldJumpOrBranch  in  1  ID redirect (already masked by stall upstream).
jumpTarget  in  32  redirect target for shouldJumpOrBranch (branch, j/jal, or jr rs).
exception  in  1  CP0 trap request (undefined, outOfMemory, interrupt).
eret  in  1  return from exception.
epc  in  32  CP0 EPC, used with eret.
id_instruction  out  32  IF/ID instruction; 32'h0 = bubble (nop).
id_pc  out  32  PC of id_instruction.
id_pcPlus4  out  32  id_pc+4, used for jal link value.
id_valid  out  1  1 when id_instruction is a real fetched word.

Behaviour:
Reset (rst=1 at a clock edge):
- pc=RESET_PC, state=FETCH, pending_target=0.
- id_instruction=0, id_pc=0, id_pcPlus4=0, id_valid=0.
- imem_req=0 during reset.

Addressing and width:
- imem_addr = pc in FETCH, = held_addr in DISCARD.
- imem_addr never changes while a request is unacknowledged.
- All targets have [1:0] forced to 0.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).

Redirect priority, highest first: exception > eret > shouldJumpOrBranch > shouldStall > sequential.
- Redirect target: EXC_VECTOR, epc, or jumpTarget respectively.

State FETCH, MIO_ready=1:
- exception / eret / branch:
  - pc <= target.
  - IF/ID <= bubble (instruction 0, id_valid 0).
  - id_pc / id_pcPlus4 hold.
  - The fetched word is squashed; there is no delay slot.
- stall: pc holds, IF/ID holds. The word is refetched next cycle.
- else:
  - id_instruction <= imem_data, id_pc <= pc, id_pcPlus4 <= pc+4, id_valid <= 1.
  - pc <= pc+4.

State FETCH, MIO_ready=0:
- redirect:
  - pending_target <= target, held_addr <= pc, state <= DISCARD.
  - IF/ID <= bubble.
- stall: pc and IF/ID hold.
- else: pc holds, IF/ID <= bubble.

State DISCARD (outstanding fetch must complete before the address moves):
- IF/ID <= bubble every cycle. shouldStall is ignored, because the bubble is already non-writing.
- A new redirect arriving in DISCARD overwrites pending_target, using the same priority.
- MIO_ready=1:
  - The word is dropped and pc <= pending_target (or the new redirect target if one arrives the same cycle).
  - state <= FETCH.

Simultaneous events:
- exception with shouldStall: the exception wins and IF/ID is bubbled.
- eret with shouldJumpOrBranch: eret wins.

Reset during DISCARD: returns to FETCH at RESET_PC. The outstanding response is ignored.

Latency:
- The first instruction appears in IF/ID on the edge where MIO_ready is first 1 after reset is released.
- With zero-wait memory, throughput is 1 instruction per cycle.
- A taken redirect costs 1 bubble.

Decomposition:
- Package pipeline_pkg holds:
  - IF state enum {FETCH, DISCARD}.
  - NOP_INSTR = 32'h0.
  - Default RESET_PC and EXC_VECTOR.
  - Shared with the ID/EX register.
- Sub-module if_id_register: 32+32+32+1 bit register with hold, bubble and load inputs.
- The PC, next-PC priority mux and FSM stay in pipeline_if_stage.

Test Plan:
1. Reset, then zero-wait memory returning 0x20080001, 0x20090002, 0x01095020 -> id_pc 0,4,8 on consecutive cycles; id_valid=1; id_pcPlus4=4,8,12.
2. shouldStall=1 for 2 cycles with id_instruction=0x8C080000 at id_pc=4 -> IF/ID and imem_addr=8 hold both cycles; the word at 8 is loaded on the 3rd cycle.
3. shouldJumpOrBranch=1 with jumpTarget=0x40 while imem_addr=0x10 -> next id_instruction=0 and id_valid=0; imem_addr=0x40 next cycle; the word at 0x10 never reaches ID.
4. MIO_ready=0 for 3 cycles at pc=0x20, with jumpTarget=0x80 asserted in cycle 1 -> imem_addr stays 0x20 until MIO_ready=1, then becomes 0x80; IF/ID is bubbled throughout.
5. exception and shouldJumpOrBranch (target 0x100) in the same cycle -> pc=0x08; next cycle eret with epc=0x14 -> pc=0x14.
6. pc=32'hFFFF_FFFC sequential fetch -> next imem_addr=0. Also: rst asserted mid-DISCARD -> imem_addr=RESET_PC and id_valid=0 on the following cycle.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the IF stage and the pipeline registers.
package pipeline_pkg;

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } IfState_t;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0008;

    // One IF/ID slot: the fetched word plus where it came from.
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
        logic        valid;
    } IfIdBundle_t;

    // Word-align an address; every redirect target goes through this.
    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register. Hold freezes everything; bubble clears the
// instruction and valid flag but keeps the pc fields; load captures a new slot.
module if_id_register
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        bubble,
    input  logic        load,
    input  IfIdBundle_t loadData,
    output IfIdBundle_t idRegs
);

    // Register update with hold > bubble > load precedence.
    always_ff @(posedge clk) begin
        if (rst) begin
            idRegs.instruction <= NOP_INSTR;
            idRegs.pc          <= 32'h0;
            idRegs.pcPlus4     <= 32'h0;
            idRegs.valid       <= 1'b0;
        end else if (!hold) begin
            if (bubble) begin
                idRegs.instruction <= NOP_INSTR;
                idRegs.valid       <= 1'b0;
            end else if (load) begin
                idRegs <= loadData;
            end
        end
    end

endmodule

// File: rtl/pipeline_if_stage.sv
// Instruction-fetch stage: PC, redirect priority mux and fetch FSM.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  FETCH   | imem_addr = pc; word accepted, squashed or held on MIO_ready
//  DISCARD | redirect taken while a fetch was outstanding; keep the old
//          | address until the response arrives, drop it, then jump
module pipeline_if_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_data,
    input  logic        MIO_ready,
    input  logic        shouldStall,
    input  logic        shouldJumpOrBranch,
    input  logic [31:0] jumpTarget,
    input  logic        exception,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pcPlus4,
    output logic        id_valid
);

    IfState_t    state, stateNext;
    logic [31:0] pc, pcNext, pcPlus4;
    logic [31:0] pendingTarget, pendingNext;
    logic [31:0] heldAddr, heldNext;
    logic [31:0] redirectTarget;
    logic        redirect;
    logic        ifHold, ifBubble, ifLoad;
    IfIdBundle_t loadData, idRegs;

    assign pcPlus4 = pc + 32'd4;

    // Redirect source selection: exception > eret > ID jump/branch.
    always_comb begin
        redirect       = exception | eret | shouldJumpOrBranch;
        redirectTarget = jumpTarget;
        if (exception) begin
            redirectTarget = EXC_VECTOR;
        end else if (eret) begin
            redirectTarget = epc;
        end
        redirectTarget = alignWord(redirectTarget);
    end

    // Next-state, next-PC and IF/ID control.
    always_comb begin
        stateNext   = state;
        pcNext      = pc;
        pendingNext = pendingTarget;
        heldNext    = heldAddr;
        ifHold      = 1'b0;
        ifBubble    = 1'b0;
        ifLoad      = 1'b0;
        case (state)
            FETCH: begin
                if (redirect) begin
                    ifBubble = 1'b1;
                    if (MIO_ready) begin
                        pcNext = redirectTarget;
                    end else begin
                        pendingNext = redirectTarget;
                        heldNext    = pc;
                        stateNext   = DISCARD;
                    end
                end else if (shouldStall) begin
                    ifHold = 1'b1;
                end else if (MIO_ready) begin
                    ifLoad = 1'b1;
                    pcNext = pcPlus4;
                end else begin
                    ifBubble = 1'b1;
                end
            end
            DISCARD: begin
                ifBubble = 1'b1;
                if (redirect) begin
                    pendingNext = redirectTarget;
                end
                if (MIO_ready) begin
                    pcNext    = redirect ? redirectTarget : pendingTarget;
                    stateNext = FETCH;
                end
            end
            default: stateNext = FETCH;
        endcase
    end

    // State, PC and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            pendingTarget <= 32'h0;
            heldAddr      <= 32'h0;
        end else begin
            state         <= stateNext;
            pc            <= pcNext;
            pendingTarget <= pendingNext;
            heldAddr      <= heldNext;
        end
    end

    assign imem_addr = (state == DISCARD) ? heldAddr : pc;
    assign imem_req  = !rst;

    assign loadData.instruction = imem_data;
    assign loadData.pc          = pc;
    assign loadData.pcPlus4     = pcPlus4;
    assign loadData.valid       = 1'b1;

    if_id_register ifIdReg (
        .clk      (clk),
        .rst      (rst),
        .hold     (ifHold),
        .bubble   (ifBubble),
        .load     (ifLoad),
        .loadData (loadData),
        .idRegs   (idRegs)
    );

    assign id_instruction = idRegs.instruction;
    assign id_pc          = idRegs.pc;
    assign id_pcPlus4     = idRegs.pcPlus4;
    assign id_valid       = idRegs.valid;

endmodule

// File: tb/tb_pipeline_if_stage.sv
// Bench for pipeline_if_stage: directed scenarios, a short random tail,
// a per-cycle comparison against a behavioural fetch model.
module tb_pipeline_if_stage;

    logic        clk = 1'b0;
    logic        rst, MIO_ready, shouldStall, shouldJumpOrBranch, exception, eret;
    logic [31:0] jumpTarget, epc, imem_data, imem_addr;
    logic        imem_req, id_valid;
    logic [31:0] id_instruction, id_pc, id_pcPlus4;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;
    bit alt4 = 1'b0;

    always #5 clk = ~clk;

    pipeline_if_stage dut (
        .clk                (clk),
        .rst                (rst),
        .imem_addr          (imem_addr),
        .imem_req           (imem_req),
        .imem_data          (imem_data),
        .MIO_ready          (MIO_ready),
        .shouldStall        (shouldStall),
        .shouldJumpOrBranch (shouldJumpOrBranch),
        .jumpTarget         (jumpTarget),
        .exception          (exception),
        .eret               (eret),
        .epc                (epc),
        .id_instruction     (id_instruction),
        .id_pc              (id_pc),
        .id_pcPlus4         (id_pcPlus4),
        .id_valid           (id_valid)
    );

    // Instruction memory contents (environment, not part of the model).
    function automatic logic [31:0] memWord(input logic [31:0] a, input bit alt);
        case (a)
            32'h0:   return 32'h2008_0001;
            32'h4:   return alt ? 32'h8C08_0000 : 32'h2009_0002;
            32'h8:   return 32'h0109_5020;
            default: return 32'hA500_0000 ^ a;
        endcase
    endfunction

    assign imem_data = memWord(imem_addr, alt4);

    // Behavioural model: fetch address, an optional "redirect waiting for the
    // outstanding response", and the IF/ID slot contents.
    logic [31:0] mPc, mPendTgt, mInstr, mIdPc, mIdP4;
    bit          mPending, mValid;

    always @(posedge clk) begin : model
        logic        hasRedir;
        logic [31:0] tgt;
        hasRedir = exception || eret || shouldJumpOrBranch;
        tgt = exception ? 32'h0000_0008 : (eret ? epc : jumpTarget);
        tgt = tgt & 32'hFFFF_FFFC;
        if (rst) begin
            mPc = 32'h0; mPending = 0; mPendTgt = 32'h0;
            mInstr = 32'h0; mValid = 0; mIdPc = 32'h0; mIdP4 = 32'h0;
        end else if (mPending) begin
            mInstr = 32'h0; mValid = 0;
            if (hasRedir) mPendTgt = tgt;
            if (MIO_ready) begin
                mPc = mPendTgt;
                mPending = 0;
            end
        end else if (hasRedir) begin
            mInstr = 32'h0; mValid = 0;
            if (MIO_ready) mPc = tgt;
            else begin
                mPending = 1;
                mPendTgt = tgt;
            end
        end else if (shouldStall) begin
            // everything holds
        end else if (MIO_ready) begin
            mInstr = memWord(mPc, alt4);
            mIdPc  = mPc;
            mIdP4  = mPc + 32'd4;
            mValid = 1;
            mPc    = mPc + 32'd4;
        end else begin
            mInstr = 32'h0; mValid = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            chk("imem_addr", imem_addr, mPc);
            chk("imem_req", {31'b0, imem_req}, {31'b0, !rst});
            chk("id_valid", {31'b0, id_valid}, {31'b0, mValid});
            chk("id_instruction", id_instruction, mInstr);
            chk("id_pc", id_pc, mIdPc);
            chk("id_pcPlus4", id_pcPlus4, mIdP4);
        end
    end

    task automatic drive(input bit r, input bit rdy, input bit st, input bit jb,
                         input logic [31:0] jt, input bit ex, input bit er,
                         input logic [31:0] ep);
        rst = r; MIO_ready = rdy; shouldStall = st; shouldJumpOrBranch = jb;
        jumpTarget = jt; exception = ex; eret = er; epc = ep;
        @(posedge clk);
        #2;
    endtask

    task automatic seq(input bit rdy);
        drive(0, rdy, 0, 0, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic jump(input logic [31:0] t, input bit rdy);
        drive(0, rdy, 0, 1, t, 0, 0, 32'h0);
    endtask

    initial begin
        drive(1, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        checkEn = 1'b1;
        drive(1, 1, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_instr", id_instruction, 32'h0);

        // zero-wait sequential fetch
        seq(1);
        chk("t1_pc0", id_pc, 32'h0);
        chk("t1_ins0", id_instruction, 32'h2008_0001);
        chk("t1_p4_0", id_pcPlus4, 32'h4);
        chk("t1_v0", {31'b0, id_valid}, 32'h1);
        seq(1);
        chk("t1_pc4", id_pc, 32'h4);
        chk("t1_ins4", id_instruction, 32'h2009_0002);
        seq(1);
        chk("t1_pc8", id_pc, 32'h8);
        chk("t1_p4_8", id_pcPlus4, 32'hC);
        chk("t1_ins8", id_instruction, 32'h0109_5020);

        // stall holds PC and IF/ID
        alt4 = 1'b1;
        drive(1, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        seq(1);
        seq(1);
        chk("t2_ins", id_instruction, 32'h8C08_0000);
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 0, 32'h0, 0, 0, 32'h0);
            chk("t2_hold_ins", id_instruction, 32'h8C08_0000);
            chk("t2_hold_pc", id_pc, 32'h4);
            chk("t2_hold_addr", imem_addr, 32'h8);
        end
        seq(1);
        chk("t2_after_pc", id_pc, 32'h8);
        chk("t2_after_ins", id_instruction, 32'h0109_5020);

        // taken branch squashes the fetched word
        seq(1);
        chk("t3_addr10", imem_addr, 32'h10);
        jump(32'h40, 1);
        chk("t3_bub_ins", id_instruction, 32'h0);
        chk("t3_bub_v", {31'b0, id_valid}, 32'h0);
        chk("t3_addr40", imem_addr, 32'h40);
        chk("t3_pc_hold", id_pc, 32'hC);
        seq(1);
        chk("t3_pc40", id_pc, 32'h40);
        chk("t3_ins40", id_instruction, 32'hA500_0040);

        // redirect while memory is busy
        jump(32'h20, 1);
        jump(32'h80, 0);
        chk("t4_addr_c1", imem_addr, 32'h20);
        seq(0);
        seq(0);
        chk("t4_addr_c3", imem_addr, 32'h20);
        chk("t4_bub", {31'b0, id_valid}, 32'h0);
        seq(1);
        chk("t4_addr80", imem_addr, 32'h80);
        chk("t4_bub2", {31'b0, id_valid}, 32'h0);
        seq(1);
        chk("t4_pc80", id_pc, 32'h80);

        // priorities
        drive(0, 1, 0, 1, 32'h100, 1, 0, 32'h0);
        chk("t5_exc", imem_addr, 32'h8);
        drive(0, 1, 0, 0, 32'h0, 0, 1, 32'h14);
        chk("t5_eret", imem_addr, 32'h14);
        drive(0, 1, 1, 0, 32'h0, 1, 0, 32'h0);
        chk("t5_exc_stall", imem_addr, 32'h8);
        chk("t5_exc_stall_v", {31'b0, id_valid}, 32'h0);
        drive(0, 1, 0, 1, 32'h100, 0, 1, 32'h30);
        chk("t5_eret_jb", imem_addr, 32'h30);
        jump(32'h80, 0);
        drive(0, 0, 0, 0, 32'h0, 1, 0, 32'h0);
        chk("t5_disc_hold", imem_addr, 32'h30);
        seq(1);
        chk("t5_disc_over", imem_addr, 32'h8);
        jump(32'h80, 0);
        jump(32'h60, 1);
        chk("t5_disc_same", imem_addr, 32'h60);

        // wrap and reset mid-DISCARD
        jump(32'hFFFF_FFFC, 1);
        chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        seq(1);
        chk("t6_wrap", imem_addr, 32'h0);
        chk("t6_wrap_p4", id_pcPlus4, 32'h0);
        jump(32'h203, 1);
        chk("t6_align", imem_addr, 32'h200);
        jump(32'h300, 0);
        drive(1, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("t6_rst_addr", imem_addr, 32'h0);
        chk("t6_rst_v", {31'b0, id_valid}, 32'h0);
        seq(1);
        chk("t6_post_pc", id_pc, 32'h0);
        chk("t6_post_addr", imem_addr, 32'h4);

        // random tail, checked by the model only
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                  $urandom, ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 15) == 0), $urandom);
        end

        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
